mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the uniciclo MIPS core. It sits beside the main ALU, downstream of the register bank. It takes `rs`/`rt` operands on a start strobe, runs a 32-iteration shift-add multiply or restoring divide, and holds the 64-bit result in HI/LO for `mfhi`/`mflo`. While `busy` is high, the control unit stalls the program counter.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width. Iteration count equals `WIDTH`.

Ports:
- `clock`  in  1  Single system clock. All state updates on its rising edge.
- `reset_n`  in  1  Reset, synchronous, active-low.
- `start`  in  1  Operation request, sampled on the rising edge.
- `op`  in  3  Operation code, encodings from the shared package.
- `a`  in  WIDTH  Operand A (`rs`, register bank read_data1).
- `b`  in  WIDTH  Operand B (`rt`, register bank read_data2).
- `busy`  out  1  High while an iteration is in progress. The PC stalls on it.
- `done`  out  1  One-cycle pulse when new mult/div results land in HI/LO.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States are IDLE, RUN and DONE. `busy` = (state == RUN). `done` = (state == DONE).
- Reset (`reset_n` low at an edge):
  - state goes to IDLE;
  - HI, LO, the iteration counter and the internal accumulators clear to 0;
  - `busy` and `done` are 0.
  - Reset has priority over `start` at the same edge.
  - Reset during RUN abandons the operation. HI/LO become 0 and `done` is not pulsed.
- A request is accepted only when state is IDLE or DONE. While in RUN, `start` is ignored (no queueing).
- MTHI/MTLO: on acceptance, HI (or LO) ← `a` at that edge. State stays or returns to IDLE, `busy` stays 0, and there is no `done` pulse.
- MULT/MULTU/DIV/DIVU: on acceptance, latch the operand magnitudes and the result signs, clear the counter, and go to RUN.
- Signed variants use the absolute values of the operands.
  - MULT product sign = sign(a) XOR sign(b).
  - DIV quotient sign = sign(a) XOR sign(b). DIV remainder sign = sign(a).
- MULTU/MULT: the 2·WIDTH-bit product goes to {HI, LO}.
- DIVU/DIV: quotient goes to LO, remainder to HI. Arithmetic is modulo 2^WIDTH.
  - Corner case: DIV of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero (b == 0, signed or unsigned): HI = `a`, LO = 0xFFFFFFFF. This case still takes the full latency.
- Reserved op codes 6 and 7: the request is ignored, with no state change.
- RUN performs one iteration per edge. After the 32nd iteration the sign fix is applied combinationally, HI/LO are written, and state goes to DONE.
- DONE lasts one cycle, then returns to IDLE unless a new request is accepted at that edge.
- HI/LO hold their values in all other cycles.

## Timing
- All timing is counted from E0, the edge at which a mult/div request is accepted.
- `busy` is high after E0 and low after E32, i.e. exactly 32 cycles.
- HI/LO are updated at E32. `done` is high from E32 to E33.
- A back-to-back request made during the DONE cycle is accepted at E33. Throughput is one operation per 33 cycles.
- MTHI/MTLO take effect at their sampling edge, so the value is readable in the next cycle.
- Outputs are pure register outputs, with no combinational path from inputs to outputs.

## Structure
- Shared package `mips_pkg` holds the op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
- The package also holds the state encoding (IDLE/RUN/DONE) and the divide-by-zero LO constant 0xFFFFFFFF.
- One sub-module, `md_iter_step`: combinational single-iteration datapath.
  - Mult mode: conditional add and shift of the {acc, multiplier} pair.
  - Div mode: trial subtract, restore, and quotient-bit shift-in.
- The top level holds the FSM, the 5-bit counter, the sign bookkeeping and the HI/LO registers.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3) → after 32 cycles, `done` pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB. `busy` is high exactly 32 cycles.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU a=100, b=0 → HI=0x64, LO=0xFFFFFFFF.
- MTHI a=0x12345678 while IDLE → HI=0x12345678 next cycle, no `busy`, no `done`. Then `start` at cycle 10 of a running MULT → ignored, and the MULT result is unchanged.
- Start DIV, then drop `reset_n` at cycle 15 → next cycle IDLE, HI=LO=0, no `done` pulse. Then assert `start` and `reset_n`=0 at the same edge → remains IDLE.
- Start a MULT, and assert `start` with MULTU 3×5 during its DONE cycle → second op accepted at that edge. Its `done` arrives 32 cycles later with HI=0, LO=15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: mult/div op codes, mult/div FSM states
// and constants used by the HI/LO unit.
package mips_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // LO value produced by any divide with a zero divisor
  localparam logic [MD_WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the mult/div datapath: shift-add multiply step or
// restoring-divide step on the {acc, mq} register pair.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, mcand};
    shifted  = {acc, mq[WIDTH-1]};
    diff     = shifted - {1'b0, mcand};
    acc_next = acc;
    mq_next  = mq;
    if (div_mode) begin
      // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b0};
      end
    end else if (mq[0]) begin
      acc_next = sum[WIDTH:1];
      mq_next  = {sum[0], mq[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[WIDTH-1:1]};
      mq_next  = {acc[0], mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers. Operations run on
// magnitudes for WIDTH cycles; signs are reapplied when the result is written.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] a_raw;
  logic             is_div;
  logic             neg_p;
  logic             neg_r;
  logic             div_zero;
  logic             op_signed;

  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   mq_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .acc      (acc),
    .mq       (mq),
    .mcand    (mcand),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  // Sign fix-up is applied to the final iteration's output in the same cycle
  always_comb begin
    prod = {acc_next, mq_next};
    if (neg_p) prod = -prod;
    quot = neg_p ? -mq_next : mq_next;
    rem  = neg_r ? -acc_next : acc_next;
  end

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      mcand    <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          acc <= acc_next;
          mq  <= mq_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            if (!is_div) begin
              {hi, lo} <= prod;
            end else if (div_zero) begin
              hi <= a_raw;
              lo <= WIDTH'(DIV0_LO);
            end else begin
              hi <= rem;
              lo <= quot;
            end
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept requests; DONE otherwise falls back to IDLE
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                acc      <= '0;
                cnt      <= '0;
                mq       <= mag(a, op_signed);
                mcand    <= mag(b, op_signed);
                a_raw    <= a;
                is_div   <= op[1];
                neg_p    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r    <= op_signed && a[WIDTH-1];
                div_zero <= op[1] && (b == '0);
                state    <= ST_RUN;
                busy     <= 1'b1;
              end
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted request on HI/LO
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin
        if (y == 0) begin m_hi = x; m_lo = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      3'd3: begin
        if (y == 0) begin m_hi = x; m_lo = 32'hFFFF_FFFF; end
        else begin m_lo = x / y; m_hi = x % y; end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Presents a request for exactly one rising edge; returns at the negedge after it
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Counts busy cycles up to the DONE cycle, then checks done and HI/LO there
  task automatic finish_md(input string tag, input int pre);
    int n;
    n = pre;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    model(o, x, y);
    issue(o, x, y);
    finish_md(tag, 0);
    @(negedge clock);
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] x, input string tag);
    model(o, x, 32'd0);
    issue(o, x, 32'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    int          seen;
    logic [2:0]  o;
    logic [31:0] x, y;

    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset_n = 1'b1;

    // Directed cases with literal expectations
    run_md(MD_MULT, 32'd7, 32'hFFFF_FFFD, "mult_7_m3");
    chk("mult_7_m3_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    chk("div_m7_2_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(MD_DIVU, 32'd100, 32'd0, "divu_by0");
    chk("divu_by0_lit", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);
    run_md(MD_DIV, 32'hFFFF_FF00, 32'd0, "div_by0_neg");
    run_md(MD_DIV, 32'd13, 32'hFFFF_FFFB, "div_13_m5");

    run_mt(MD_MTHI, 32'h1234_5678, "mthi");
    chk("mthi_lit", 64'(hi), 64'h1234_5678);
    run_mt(MD_MTLO, 32'hCAFE_F00D, "mtlo");

    // Requests arriving mid-run are dropped
    model(MD_MULT, 32'd1234, 32'hFFFF_FF85);
    issue(MD_MULT, 32'd1234, 32'hFFFF_FF85);
    repeat (9) @(negedge clock);
    start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0;
    finish_md("mult_ignore_start", 10);
    @(negedge clock);

    // Reset mid-divide abandons the op without a done pulse
    issue(MD_DIV, 32'h7654_3210, 32'd3);
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    chk("rst_run_busy", 64'(busy), 64'd0);
    chk("rst_run_hi", 64'(hi), 64'd0);
    chk("rst_run_lo", 64'(lo), 64'd0);
    seen = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clock);
    end
    chk("rst_run_no_done", 64'(seen), 64'd0);

    // Reset wins over start at the same edge
    start = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd5; reset_n = 1'b0;
    @(negedge clock);
    start = 1'b0; reset_n = 1'b1;
    chk("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clock);
    chk("rst_start_busy2", 64'(busy), 64'd0);
    chk("rst_start_hi", 64'(hi), 64'd0);

    // Back-to-back request accepted in the DONE cycle
    model(MD_MULT, 32'hFFFF_0001, 32'd77);
    issue(MD_MULT, 32'hFFFF_0001, 32'd77);
    finish_md("b2b_first", 0);
    start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd5;
    model(MD_MULTU, 32'd3, 32'd5);
    @(negedge clock);
    start = 1'b0;
    chk("b2b_accepted", 64'(busy), 64'd1);
    finish_md("b2b_second", 0);
    chk("b2b_second_lit", {hi, lo}, 64'd15);
    @(negedge clock);

    // Reserved op codes leave everything untouched
    issue(3'd6, 32'hAAAA_AAAA, 32'd1);
    chk("rsv6_busy", 64'(busy), 64'd0);
    chk("rsv6_hilo", {hi, lo}, {m_hi, m_lo});

    // Random mix
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (o <= 3'd3) begin
        run_md(o, x, y, "rand_md");
      end else if (o <= 3'd5) begin
        run_mt(o, x, "rand_mt");
      end else begin
        issue(o, x, y);
        chk("rand_rsv_busy", 64'(busy), 64'd0);
        chk("rand_rsv_hilo", {hi, lo}, {m_hi, m_lo});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
